// File: rtl/rgb_blob_bbox_if.sv
// Pixel-stream and result bundle for rgb_blob_bbox.
// The source drives the master side and the blob block sits on the slave side.
// Handshake: iDval qualifies one pixel per cycle and there is no ready, so the sink always accepts.
// oBinDval likewise qualifies oBin, and oDone marks a cycle in which the result fields change.
interface rgb_blob_bbox_if #(
   parameter int DW = 12,
   parameter int CW = 16
);
   logic [DW-1:0]   iRed;
   logic [DW-1:0]   iGreen;
   logic [DW-1:0]   iBlue;
   logic            iDval;
   logic            iSOF;
   logic [DW-1:0]   iThreshold;
   logic            oBin;
   logic            oBinDval;
   logic [CW-1:0]   oX_Min;
   logic [CW-1:0]   oX_Max;
   logic [CW-1:0]   oY_Min;
   logic [CW-1:0]   oY_Max;
   logic [2*CW-1:0] oCount;
   logic            oBoxValid;
   logic            oDone;

   modport master (
      output iRed, iGreen, iBlue, iDval, iSOF, iThreshold,
      input  oBin, oBinDval, oX_Min, oX_Max, oY_Min, oY_Max, oCount, oBoxValid, oDone
   );

   modport slave (
      input  iRed, iGreen, iBlue, iDval, iSOF, iThreshold,
      output oBin, oBinDval, oX_Min, oX_Max, oY_Min, oY_Max, oCount, oBoxValid, oDone
   );
endinterface

// File: rtl/rgb_blob_bbox.sv
// Luma threshold mask plus per-frame bounding box and bright-pixel count.
// There are two pipeline stages: luma and coordinates, then compare and accumulate.
module rgb_blob_bbox #(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480,
   parameter int DW    = 12,
   parameter int CW    = 16
) (
   input logic          iCLK,
   input logic          iRST,
   rgb_blob_bbox_if.slave bus
);
   localparam logic [CW-1:0]   X_LAST  = CW'(IMG_W - 1);
   localparam logic [CW-1:0]   Y_LAST  = CW'(IMG_H - 1);
   localparam logic [CW-1:0]   C_ONE   = CW'(1);
   localparam logic [2*CW-1:0] CNT_ONE = (2*CW)'(1);

   logic [CW-1:0]   xCnt, yCnt, curX, curY;
   logic            lastPix;
   logic [DW+1:0]   lumaSum;

   logic            s1Valid, s1Last;
   logic [DW-1:0]   s1Luma, s1Thr;
   logic [CW-1:0]   s1X, s1Y;

   logic [CW-1:0]   accXMin, accXMax, accYMin, accYMax;
   logic [2*CW-1:0] accCount;
   logic [CW-1:0]   nxtXMin, nxtXMax, nxtYMin, nxtYMax;
   logic [2*CW-1:0] nxtCount;
   logic            hit, closeFrame;

   // A pixel arriving together with iSOF is already (0,0) of the new frame.
   always_comb begin
      curX    = bus.iSOF ? '0 : xCnt;
      curY    = bus.iSOF ? '0 : yCnt;
      lastPix = bus.iDval && (curX == X_LAST) && (curY == Y_LAST);
      lumaSum = {2'b00, bus.iRed} + {1'b0, bus.iGreen, 1'b0} + {2'b00, bus.iBlue};
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         xCnt <= '0;
         yCnt <= '0;
      end else if (bus.iDval) begin
         if (lastPix) begin
            xCnt <= '0;
            yCnt <= '0;
         end else if (curX == X_LAST) begin
            xCnt <= '0;
            yCnt <= curY + C_ONE;
         end else begin
            xCnt <= curX + C_ONE;
            yCnt <= curY;
         end
      end else if (bus.iSOF) begin
         xCnt <= '0;
         yCnt <= '0;
      end
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         s1Valid <= 1'b0;
         s1Last  <= 1'b0;
         s1Luma  <= '0;
         s1Thr   <= '0;
         s1X     <= '0;
         s1Y     <= '0;
      end else begin
         s1Valid <= bus.iDval;
         s1Last  <= lastPix;
         s1Luma  <= lumaSum[DW+1:2];
         s1Thr   <= bus.iThreshold;
         s1X     <= curX;
         s1Y     <= curY;
      end
   end

   // A stage-1 pixel still belonging to the old frame is dropped when iSOF arrives.
   always_comb begin
      hit        = s1Valid && (s1Luma > s1Thr);
      closeFrame = s1Valid && s1Last && !bus.iSOF;
      nxtXMin    = (hit && (s1X < accXMin)) ? s1X : accXMin;
      nxtXMax    = (hit && (s1X > accXMax)) ? s1X : accXMax;
      nxtYMin    = (hit && (s1Y < accYMin)) ? s1Y : accYMin;
      nxtYMax    = (hit && (s1Y > accYMax)) ? s1Y : accYMax;
      nxtCount   = (hit && (accCount != '1)) ? accCount + CNT_ONE : accCount;
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         bus.oBin      <= 1'b0;
         bus.oBinDval  <= 1'b0;
         bus.oDone     <= 1'b0;
         bus.oX_Min    <= '0;
         bus.oX_Max    <= '0;
         bus.oY_Min    <= '0;
         bus.oY_Max    <= '0;
         bus.oCount    <= '0;
         bus.oBoxValid <= 1'b0;
         accXMin       <= '1;
         accXMax       <= '0;
         accYMin       <= '1;
         accYMax       <= '0;
         accCount      <= '0;
      end else begin
         bus.oBin     <= hit;
         bus.oBinDval <= s1Valid;
         bus.oDone    <= closeFrame;
         if (bus.iSOF || closeFrame) begin
            accXMin  <= '1;
            accXMax  <= '0;
            accYMin  <= '1;
            accYMax  <= '0;
            accCount <= '0;
         end else begin
            accXMin  <= nxtXMin;
            accXMax  <= nxtXMax;
            accYMin  <= nxtYMin;
            accYMax  <= nxtYMax;
            accCount <= nxtCount;
         end
         // An empty frame publishes an all-zero box rather than the empty-state sentinels.
         if (closeFrame) begin
            bus.oX_Min    <= (nxtCount == '0) ? '0 : nxtXMin;
            bus.oX_Max    <= (nxtCount == '0) ? '0 : nxtXMax;
            bus.oY_Min    <= (nxtCount == '0) ? '0 : nxtYMin;
            bus.oY_Max    <= (nxtCount == '0) ? '0 : nxtYMax;
            bus.oCount    <= nxtCount;
            bus.oBoxValid <= (nxtCount != '0);
         end
      end
   end
endmodule

// File: tb/tb_rgb_blob_bbox.sv
// Directed bench for rgb_blob_bbox on a 4x4 image.
// It covers the mask stream with latency, frame results, iSOF abort and mid-frame reset.
module tb_rgb_blob_bbox;
   logic iCLK = 1'b0;
   logic iRST;
   int   cyc = 0;
   int   nCompared = 0;
   int   nMismatched = 0;
   int   doneCnt = 0;
   int   doneBefore;
   logic [0:0] expQ[$];
   int         expCycQ[$];

   rgb_blob_bbox_if #(.DW(12), .CW(16)) bus ();

   rgb_blob_bbox #(.IMG_W(4), .IMG_H(4), .DW(12), .CW(16)) dut (
      .iCLK (iCLK),
      .iRST (iRST),
      .bus  (bus)
   );

   always #5 iCLK = ~iCLK;
   always @(posedge iCLK) cyc <= cyc + 1;

   task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nCompared++;
      if (got !== exp) begin
         nMismatched++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // The mask monitor checks each beat's value, latency and idle-zero behaviour.
   always @(negedge iCLK) begin
      if (bus.oBinDval) begin
         if (expQ.size() == 0) begin
            checkValue("mask_unexpected", 32'd1, 32'd0);
         end else begin
            checkValue("mask_bin", {31'd0, bus.oBin}, {31'd0, expQ.pop_front()});
            checkValue("mask_latency", cyc, expCycQ.pop_front());
         end
      end else begin
         checkValue("mask_idle_zero", {31'd0, bus.oBin}, 32'd0);
      end
      if (bus.oDone) begin
         doneCnt++;
         checkValue("done_with_mask", {31'd0, bus.oBinDval}, 32'd1);
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge iCLK); #1;
         bus.iDval = 1'b0;
         bus.iSOF  = 1'b0;
      end
   endtask

   task automatic drivePix(input logic [11:0] r, g, b, thr, input logic sof, input logic e);
      @(posedge iCLK); #1;
      bus.iRed       = r;
      bus.iGreen     = g;
      bus.iBlue      = b;
      bus.iThreshold = thr;
      bus.iDval      = 1'b1;
      bus.iSOF       = sof;
      expQ.push_back(e);
      expCycQ.push_back(cyc + 2);
   endtask

   // Modes: 0 all at 200 with thr 199; 1 bright at (1,2) and (3,1); 2 dark; 3 bright at (2,3).
   task automatic sendFrame(input int mode, input logic sofFirst, input int nPix, input int maxGap);
      for (int i = 0; i < nPix; i++) begin
         int x, y;
         logic bright;
         logic [11:0] v;
         logic [11:0] thr;
         x = i % 4;
         y = i / 4;
         thr = 12'd100;
         case (mode)
            0: begin bright = 1'b1; v = 12'd200; thr = 12'd199; end
            1: begin bright = (x == 1 && y == 2) || (x == 3 && y == 1); v = bright ? 12'd4095 : 12'd0; end
            3: begin bright = (x == 2 && y == 3); v = bright ? 12'd4095 : 12'd0; end
            default: begin bright = 1'b0; v = 12'd0; end
         endcase
         drivePix(v, v, v, thr, sofFirst && (i == 0), bright);
         if (maxGap > 0) idle($urandom_range(0, maxGap));
      end
   endtask

   task automatic checkResults(input int xMin, xMax, yMin, yMax, cnt, bv);
      checkValue("x_min", 32'(bus.oX_Min), xMin);
      checkValue("x_max", 32'(bus.oX_Max), xMax);
      checkValue("y_min", 32'(bus.oY_Min), yMin);
      checkValue("y_max", 32'(bus.oY_Max), yMax);
      checkValue("count", bus.oCount, cnt);
      checkValue("box_valid", {31'd0, bus.oBoxValid}, bv);
   endtask

   initial begin
      iRST = 1'b1;
      bus.iRed = '0; bus.iGreen = '0; bus.iBlue = '0;
      bus.iThreshold = '0; bus.iDval = 1'b0; bus.iSOF = 1'b0;
      idle(3);
      iRST = 1'b0;
      checkResults(0, 0, 0, 0, 0, 0);
      checkValue("reset_done", {31'd0, bus.oDone}, 32'd0);
      checkValue("reset_bindval", {31'd0, bus.oBinDval}, 32'd0);

      // Uniform bright frame, started with iSOF on its first pixel
      doneBefore = doneCnt;
      sendFrame(0, 1'b1, 16, 0);
      idle(4);
      checkValue("uniform_done", doneCnt - doneBefore, 32'd1);
      checkResults(0, 3, 0, 3, 16, 1);

      // Two bright pixels, counters wrapped by themselves
      doneBefore = doneCnt;
      sendFrame(1, 1'b0, 16, 0);
      idle(4);
      checkValue("bbox_done", doneCnt - doneBefore, 32'd1);
      checkResults(1, 3, 1, 2, 2, 1);

      // Luma 2047 against thresholds on either side; leaves a partial frame
      doneBefore = doneCnt;
      drivePix(12'd0, 12'd4095, 12'd0, 12'd2047, 1'b0, 1'b0);
      drivePix(12'd0, 12'd4095, 12'd0, 12'd2046, 1'b0, 1'b1);
      idle(4);
      checkValue("edge_no_done", doneCnt - doneBefore, 32'd0);
      checkResults(1, 3, 1, 2, 2, 1);

      // Dark frame with random gaps, iSOF discards the partial frame
      doneBefore = doneCnt;
      sendFrame(2, 1'b1, 16, 2);
      idle(4);
      checkValue("empty_done", doneCnt - doneBefore, 32'd1);
      checkResults(0, 0, 0, 0, 0, 0);

      // Abort after 9 bright pixels, then a full frame with one bright pixel
      doneBefore = doneCnt;
      sendFrame(0, 1'b1, 9, 0);
      sendFrame(3, 1'b1, 16, 0);
      idle(4);
      checkValue("abort_done", doneCnt - doneBefore, 32'd1);
      checkResults(2, 2, 3, 3, 1, 1);

      // Reset in mid-frame clears results and produces no done
      doneBefore = doneCnt;
      sendFrame(0, 1'b0, 5, 0);
      idle(3);
      iRST = 1'b1;
      idle(3);
      iRST = 1'b0;
      checkValue("midreset_no_done", doneCnt - doneBefore, 32'd0);
      checkResults(0, 0, 0, 0, 0, 0);

      // A frame after reset relies on the counters restarting at (0,0)
      doneBefore = doneCnt;
      sendFrame(1, 1'b0, 16, 0);
      idle(4);
      checkValue("recover_done", doneCnt - doneBefore, 32'd1);
      checkResults(1, 3, 1, 2, 2, 1);

      checkValue("queue_drained", expQ.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end
endmodule
